fwd_scoreboard: RTL and testbench

- Parametrised scoreboard-based forwarding/hazard unit for the 5-stage MIPS pipeline; successor to the combinational per-stage address-compare forwarding logic.
- Tracks every in-flight register write with a per-register countdown, so variable-latency producers (ALU, load, multi-cycle multiply) are handled by one block.
- Sits beside the ID stage: it receives the issuing instruction's destination and latency and the NUM_SRC source operands of the instruction in ID.
- It produces the stall request plus registered bypass selects, aligned to the cycle the consumer occupies EX.

---
 rtl/fwd_scoreboard.sv | 114 +++++++++++
 tb/tb_fwd_scoreboard.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Scoreboard forwarding/hazard unit: per-register countdown of in-flight writes,
// producing a combinational stall request and registered per-operand bypass selects.
module fwd_scoreboard #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned MAX_LAT = 6,
   parameter int unsigned CNT_W   = 3,
   parameter int unsigned PERF_W  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        iss_valid,
   input  logic                        iss_wr,
   input  logic [REG_AW-1:0]           iss_dst,
   input  logic [CNT_W-1:0]            iss_lat,
   input  logic [NUM_SRC-1:0]          src_used,
   input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
   output logic                        stall_out,
   output logic [NUM_SRC*2-1:0]        fwd_sel,
   output logic                        busy,
   output logic [PERF_W-1:0]           stall_cnt
);

   localparam int unsigned NREG = 1 << REG_AW;

   localparam logic [1:0] SEL_RF   = 2'b00;
   localparam logic [1:0] SEL_TAP1 = 2'b01;
   localparam logic [1:0] SEL_TAP2 = 2'b10;

   logic [CNT_W-1:0]     cnt_q [1:NREG-1];
   logic [CNT_W-1:0]     cnt_d [1:NREG-1];
   logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;
   logic                 busy_q, busy_d;
   logic [PERF_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic [CNT_W-1:0]     lat_eff;
   logic [CNT_W-1:0]     lat_p1;
   logic [CNT_W-1:0]     dst_cnt;
   logic                 waw_hzd;
   logic                 raw_hzd;
   logic                 issue_en;
   logic [NUM_SRC*2-1:0] sel_c;
   logic [REG_AW-1:0]    q_addr;
   logic [CNT_W-1:0]     q_cnt;

   // Register 0 has no table entry and always reads as idle.
   function automatic logic [CNT_W-1:0] rd_cnt(input logic [REG_AW-1:0] a);
      logic [CNT_W-1:0] v;
      v = '0;
      if (a != '0) v = cnt_q[a];
      return v;
   endfunction

   // Issue qualification, latency clamp and WAW check.
   always_comb begin
      lat_eff = iss_lat;
      if ((iss_lat == '0) || (iss_lat > CNT_W'(MAX_LAT))) lat_eff = CNT_W'(MAX_LAT);
      lat_p1  = lat_eff + CNT_W'(1);
      dst_cnt = rd_cnt(iss_dst);
      waw_hzd = iss_valid & iss_wr & (iss_dst != '0) & (dst_cnt > lat_p1);
   end

   // Per-port classification against pre-update table state.
   always_comb begin
      sel_c   = '0;
      raw_hzd = 1'b0;
      q_addr  = '0;
      q_cnt   = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         q_addr = src_addr[k*REG_AW +: REG_AW];
         q_cnt  = rd_cnt(q_addr);
         if (src_used[k] && (q_addr != '0)) begin
            if (q_cnt == CNT_W'(1))      sel_c[k*2 +: 2] = SEL_TAP2;
            else if (q_cnt == CNT_W'(2)) sel_c[k*2 +: 2] = SEL_TAP1;
            else if (q_cnt != '0)        raw_hzd = 1'b1;
         end
      end
   end

   assign stall_out = raw_hzd | waw_hzd;
   assign issue_en  = iss_valid & iss_wr & ~stall_out & (iss_dst != '0);

   // Countdown with issue override, plus output next-state.
   always_comb begin
      busy_d = 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
         if (issue_en && (iss_dst == REG_AW'(r))) cnt_d[r] = lat_p1;
         busy_d = busy_d | (cnt_d[r] != '0);
      end
      fwd_sel_d   = stall_out ? '0 : sel_c;
      stall_cnt_d = stall_cnt_q;
      if (stall_out && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 1; r < NREG; r++) cnt_q[r] <= '0;
         fwd_sel_q   <= '0;
         busy_q      <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         fwd_sel_q   <= fwd_sel_d;
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fwd_sel   = fwd_sel_q;
   assign busy      = busy_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: ALU/load/multiply forwarding, WAW, r0 and reset.
module tb_fwd_scoreboard;

   localparam int unsigned REG_AW  = 5;
   localparam int unsigned NUM_SRC = 3;
   localparam int unsigned MAX_LAT = 6;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned PERF_W  = 16;

   logic                      clk;
   logic                      reset;
   logic                      iss_valid;
   logic                      iss_wr;
   logic [REG_AW-1:0]         iss_dst;
   logic [CNT_W-1:0]          iss_lat;
   logic [NUM_SRC-1:0]        src_used;
   logic [NUM_SRC*REG_AW-1:0] src_addr;
   logic                      stall_out;
   logic [NUM_SRC*2-1:0]      fwd_sel;
   logic                      busy;
   logic [PERF_W-1:0]         stall_cnt;

   int checks;
   int failures;

   fwd_scoreboard #(
      .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_wr(iss_wr),
      .iss_dst(iss_dst), .iss_lat(iss_lat), .src_used(src_used), .src_addr(src_addr),
      .stall_out(stall_out), .fwd_sel(fwd_sel), .busy(busy), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset && iss_valid && iss_wr && !stall_out)
         assert (iss_lat >= 1 && iss_lat <= MAX_LAT)
            else $error("iss_lat out of range: %0d", iss_lat);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 1'b0;
      iss_wr    = 1'b0;
      iss_dst   = '0;
      iss_lat   = 3'd1;
      src_used  = '0;
      src_addr  = '0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic issue(input logic [REG_AW-1:0] dst, input logic [CNT_W-1:0] lat);
      idle();
      iss_valid = 1'b1;
      iss_wr    = 1'b1;
      iss_dst   = dst;
      iss_lat   = lat;
   endtask

   task automatic consume(input logic [NUM_SRC-1:0] used, input logic [REG_AW-1:0] a0,
                          input logic [REG_AW-1:0] a1, input logic [REG_AW-1:0] a2);
      idle();
      iss_valid = 1'b1;
      src_used  = used;
      src_addr  = {a2, a1, a0};
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #3;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_out); end
      checks++; if (fwd_sel !== 6'b0) begin failures++; $display("FAIL rst_fwd got=%b exp=000000", fwd_sel); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_scnt got=%0d exp=0", stall_cnt); end
      step(); step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_alu_chain();
      issue(5'd8, 3'd1);
      step();
      consume(3'b001, 5'd8, 5'd0, 5'd0);
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b000001) begin failures++; $display("FAIL alu_fwd got=%b exp=000001", fwd_sel); end
      drain();
   endtask

   task automatic test_gap();
      issue(5'd8, 3'd1);
      step();
      consume(3'b000, 5'd0, 5'd0, 5'd0);
      step();
      consume(3'b010, 5'd0, 5'd8, 5'd0);
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL gap1_stall got=%b exp=0", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b001000) begin failures++; $display("FAIL gap1_fwd got=%b exp=001000", fwd_sel); end
      drain();
      issue(5'd8, 3'd1);
      step();
      consume(3'b000, 5'd0, 5'd0, 5'd0);
      step();
      consume(3'b000, 5'd0, 5'd0, 5'd0);
      step();
      consume(3'b010, 5'd0, 5'd8, 5'd0);
      step();
      checks++; if (fwd_sel !== 6'b000000) begin failures++; $display("FAIL gap2_fwd got=%b exp=000000", fwd_sel); end
      drain();
   endtask

   task automatic test_load_use();
      issue(5'd9, 3'd2);
      step();
      consume(3'b001, 5'd9, 5'd0, 5'd0);
      checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL ld_stall got=%b exp=1", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b000000) begin failures++; $display("FAIL ld_bubble got=%b exp=000000", fwd_sel); end
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL ld_release got=%b exp=0", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b000001) begin failures++; $display("FAIL ld_fwd got=%b exp=000001", fwd_sel); end
      checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL ld_scnt got=%0d exp=1", stall_cnt); end
      drain();
   endtask

   task automatic test_multiply();
      int n;
      issue(5'd10, 3'd5);
      step();
      consume(3'b001, 5'd10, 5'd0, 5'd0);
      n = 0;
      while (stall_out === 1'b1 && n < 10) begin n++; step(); end
      checks++; if (n != 4) begin failures++; $display("FAIL mul_stalls got=%0d exp=4", n); end
      checks++; if (fwd_sel !== 6'b000000) begin failures++; $display("FAIL mul_bubble got=%b exp=000000", fwd_sel); end
      step();
      checks++; if (fwd_sel !== 6'b000001) begin failures++; $display("FAIL mul_fwd got=%b exp=000001", fwd_sel); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy5 got=%b exp=1", busy); end
      idle();
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy6 got=%b exp=0", busy); end
      checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL mul_scnt got=%0d exp=5", stall_cnt); end
      drain();
   endtask

   task automatic test_waw_zero();
      int n;
      issue(5'd3, 3'd5);
      step();
      idle();
      step();
      issue(5'd3, 3'd1);
      #1;
      n = 0;
      while (stall_out === 1'b1 && n < 10) begin n++; step(); end
      checks++; if (n != 3) begin failures++; $display("FAIL waw_stalls got=%0d exp=3", n); end
      step();
      consume(3'b001, 5'd3, 5'd0, 5'd3);
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL waw_cons_stall got=%b exp=0", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b000001) begin failures++; $display("FAIL waw_fwd got=%b exp=000001", fwd_sel); end
      drain();
      issue(5'd0, 3'd5);
      src_used = 3'b111;
      src_addr = '0;
      #1;
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", stall_out); end
      step();
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL r0_stall2 got=%b exp=0", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b000000) begin failures++; $display("FAIL r0_fwd got=%b exp=000000", fwd_sel); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL r0_busy got=%b exp=0", busy); end
      drain();
   endtask

   task automatic test_reset_mid();
      issue(5'd12, 3'd5);
      step();
      idle();
      step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_pre got=%b exp=1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rm_scnt got=%0d exp=0", stall_cnt); end
      step();
      reset = 1'b1;
      consume(3'b001, 5'd12, 5'd0, 5'd0);
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL rm_stall got=%b exp=0", stall_out); end
      step();
      checks++; if (fwd_sel !== 6'b000000) begin failures++; $display("FAIL rm_fwd got=%b exp=000000", fwd_sel); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rm_scnt2 got=%0d exp=0", stall_cnt); end
      drain();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      idle();
      test_reset();
      test_alu_chain();
      test_gap();
      test_load_use();
      test_multiply();
      test_waw_zero();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
